register_writeback: RTL and testbench



---
 rtl/register_writeback_pkg.sv | 13 +
 rtl/register_writeback_fifo.sv | 53 +++++
 rtl/register_writeback.sv | 147 ++++++++++++++
 tb/tb_register_writeback.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_writeback_pkg.sv
// rtl/register_writeback_pkg.sv - shared widths, zero-register constant and write request type
package register_writeback_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/register_writeback_fifo.sv
// rtl/register_writeback_fifo.sv - synchronous FIFO of pending long-path write requests
module wb_fifo
    import register_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Push,
    input  wb_req_t                PushData,
    input  logic                   Pop,
    output wb_req_t                PopData,
    output logic                   Full,
    output logic                   Empty,
    output logic [$clog2(DEPTH):0] Count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic doPush;
    logic doPop;

    assign doPush  = Push && !Full;
    assign doPop   = Pop && !Empty;
    assign Full    = (Count == CNT_W'(DEPTH));
    assign Empty   = (Count == '0);
    assign PopData = mem[rdPtr];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            unique case ({doPush, doPop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers and Count.
    always_ff @(posedge Clk) begin
        if (doPush) mem[wrPtr] <= PushData;
    end

endmodule

// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - arbitrates ALU and long-path results onto the register file write port
module register_writeback
    import register_writeback_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    input  logic              AluValid,
    input  logic [ADDR_W-1:0] AluReg,
    input  logic [DATA_W-1:0] AluData,
    input  logic              LongValid,
    output logic              LongReady,
    input  logic [ADDR_W-1:0] LongReg,
    input  logic [DATA_W-1:0] LongData,
    output logic              AluStall,
    output logic [31:0]       Pending,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData
);
    localparam int NREG     = 1 << ADDR_W;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIM + 1);
    localparam logic [ADDR_W-1:0]   ZERO_ADDR  = ADDR_W'(ZERO_REG);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    logic              readyEn;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPush;
    logic              fifoPop;
    logic [CNT_W-1:0]  fifoCount;
    wb_req_t           pushReq;
    wb_req_t           headReq;
    logic              aluLive;
    logic              wrEn;
    logic [ADDR_W-1:0] wrReg;
    logic [DATA_W-1:0] wrData;
    logic [STARVE_W-1:0] starveCnt;
    logic [STARVE_W-1:0] starveNext;

    // readyEn keeps LongReady low until the first edge after reset release.
    assign LongReady    = readyEn && !fifoFull;
    assign fifoPush     = LongValid && LongReady && (LongReg != ZERO_ADDR);
    assign pushReq.addr = LongReg;
    assign pushReq.data = LongData;
    assign aluLive      = AluValid && !AluStall && (AluReg != ZERO_ADDR);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Push     (fifoPush),
        .PushData (pushReq),
        .Pop      (fifoPop),
        .PopData  (headReq),
        .Full     (fifoFull),
        .Empty    (fifoEmpty),
        .Count    (fifoCount)
    );

    always_comb begin
        fifoPop = 1'b0;
        wrEn    = 1'b0;
        wrReg   = headReq.addr;
        wrData  = headReq.data;
        if (AluStall && !fifoEmpty) begin
            fifoPop = 1'b1;
            wrEn    = 1'b1;
        end else if (aluLive) begin
            wrEn   = 1'b1;
            wrReg  = AluReg;
            wrData = AluData;
        end else if (!fifoEmpty) begin
            fifoPop = 1'b1;
            wrEn    = 1'b1;
        end
    end

    always_comb begin
        starveNext = starveCnt;
        if (fifoEmpty || fifoPop) begin
            starveNext = '0;
        end else if (starveCnt < STARVE_MAX) begin
            starveNext = starveCnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            AluStall      <= 1'b0;
            starveCnt     <= '0;
            readyEn       <= 1'b0;
        end else begin
            RegWrite      <= wrEn;
            WriteRegister <= wrReg;
            WriteData     <= wrData;
            starveCnt     <= starveNext;
            AluStall      <= (starveCnt >= STARVE_MAX);
            readyEn       <= 1'b1;
        end
    end

    assign Pending[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_pend
        logic [1:0] cnt;
        logic       inc;
        logic       dec;

        assign inc = IssueValid && (IssueReg == ADDR_W'(i));
        assign dec = RegWrite && (WriteRegister == ADDR_W'(i));

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                cnt <= 2'd0;
            end else if (inc && !dec && cnt != 2'd3) begin
                cnt <= cnt + 2'd1;
            end else if (dec && !inc && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
        end

        assign Pending[i] = (cnt != 2'd0);

        a_issue_overflow: assert property (@(posedge Clk) disable iff (!Rst_n)
            !(inc && !dec && cnt == 2'd3));
        a_commit_underflow: assert property (@(posedge Clk) disable iff (!Rst_n)
            !(dec && cnt == 2'd0));
    end

    a_alu_during_stall: assert property (@(posedge Clk) disable iff (!Rst_n)
        !(AluValid && AluStall));
    a_fifo_bound: assert property (@(posedge Clk) disable iff (!Rst_n)
        fifoCount <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_register_writeback.sv
// tb/tb_register_writeback.sv - randomized scoreboard bench for register_writeback
module tb_register_writeback;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int LIM    = 8;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              IssueValid = 1'b0;
    logic [ADDR_W-1:0] IssueReg = '0;
    logic              AluValid = 1'b0;
    logic [ADDR_W-1:0] AluReg = '0;
    logic [DATA_W-1:0] AluData = '0;
    logic              LongValid = 1'b0;
    logic              LongReady;
    logic [ADDR_W-1:0] LongReg = '0;
    logic [DATA_W-1:0] LongData = '0;
    logic              AluStall;
    logic [31:0]       Pending;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;

    always #5 Clk = ~Clk;

    register_writeback #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .IssueValid(IssueValid), .IssueReg(IssueReg),
        .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
        .LongValid(LongValid), .LongReady(LongReady), .LongReg(LongReg), .LongData(LongData),
        .AluStall(AluStall), .Pending(Pending),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
    );

    typedef struct { int stamp; int rg; logic [31:0] data; } exp_t;
    typedef struct { int rg; logic [31:0] data; } item_t;

    exp_t  expQ[$];
    item_t mFifo[$];
    int    mLoss = 0;
    bit    mStall = 0;
    bit    mReadyOn = 0;
    int    mPend[32];
    bit    mPrevWr = 0;
    int    mPrevReg = 0;
    int    outstanding[32];
    int    cyc = 0;
    int    nChecks = 0;
    int    nFails = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write the DUT presents must be the oldest expected write, in the expected cycle.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (RegWrite) begin
                if (expQ.size() == 0) begin
                    check("write_when_idle", RegWrite, 1'b0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("write_cycle", cyc, e.stamp);
                    check("write_reg", WriteRegister, e.rg);
                    check("write_data", WriteData, e.data);
                end
            end else if (expQ.size() > 0 && expQ[0].stamp <= cyc) begin
                check("missing_write", RegWrite, 1'b1);
                void'(expQ.pop_front());
            end
        end
    end

    task automatic model_clear();
        expQ.delete();
        mFifo.delete();
        mLoss = 0; mStall = 0; mReadyOn = 0; mPrevWr = 0; mPrevReg = 0;
        for (int r = 0; r < 32; r++) begin
            mPend[r] = 0;
            outstanding[r] = 0;
        end
    endtask

    // One cycle: check status after the last edge, drive inputs, and predict the next edge.
    task automatic step(input bit iv, input int ir, input bit av, input int ar, input logic [31:0] ad,
                        input bit lv, input int lr, input logic [31:0] ld,
                        output bit aluAcc, output bit longAcc);
        bit expReady, hadHead, popped, wr, newStall;
        int wrReg;
        logic [31:0] wrData, pendExp;
        expReady = mReadyOn && (mFifo.size() < DEPTH);
        pendExp = '0;
        for (int r = 1; r < 32; r++) if (mPend[r] != 0) pendExp[r] = 1'b1;
        check("alu_stall", AluStall, mStall);
        check("long_ready", LongReady, expReady);
        check("pending", Pending, pendExp);
        if (mStall) av = 0;
        IssueValid = iv; IssueReg = ADDR_W'(ir);
        AluValid = av;   AluReg = ADDR_W'(ar);   AluData = ad;
        LongValid = lv;  LongReg = ADDR_W'(lr);  LongData = ld;
        aluAcc  = av && ar != 0;
        longAcc = lv && expReady;
        hadHead = mFifo.size() > 0;
        popped = 0; wr = 0; wrReg = 0; wrData = '0;
        if (mStall && hadHead) popped = 1;
        else if (aluAcc) begin wr = 1; wrReg = ar; wrData = ad; end
        else if (hadHead) popped = 1;
        if (popped) begin
            wr = 1; wrReg = mFifo[0].rg; wrData = mFifo[0].data;
            void'(mFifo.pop_front());
        end
        newStall = (mLoss >= LIM);
        if (hadHead && !popped) mLoss = (mLoss < LIM) ? mLoss + 1 : mLoss;
        else mLoss = 0;
        mStall = newStall;
        if (longAcc && lr != 0) mFifo.push_back('{lr, ld});
        if (wr) expQ.push_back('{cyc + 1, wrReg, wrData});
        if (iv && ir != 0) mPend[ir]++;
        if (mPrevWr) mPend[mPrevReg]--;
        mPrevWr = wr; mPrevReg = wrReg;
        mReadyOn = 1;
        @(posedge Clk); #1;
    endtask

    task automatic idle(input int n);
        bit a, l;
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0, 0, 0, '0, a, l);
    endtask

    task automatic drain();
        int guard = 0;
        while ((mFifo.size() > 0 || expQ.size() > 0 || mStall) && guard < 200) begin
            idle(1);
            guard++;
        end
        check("drain_done", guard < 200, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check("rst_regwrite", RegWrite, 1'b0);
        check("rst_wreg", WriteRegister, '0);
        check("rst_wdata", WriteData, '0);
        check("rst_stall", AluStall, 1'b0);
        check("rst_pending", Pending, '0);
        check("rst_ready", LongReady, 1'b0);
    endtask

    task automatic mid_reset();
        Rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        IssueValid = 0; AluValid = 0; LongValid = 0;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    function automatic int pick();
        int s, r;
        s = $urandom_range(30);
        for (int k = 0; k < 31; k++) begin
            r = 1 + (s + k) % 31;
            if (outstanding[r] > 0) return r;
        end
        return -1;
    endfunction

    task automatic rand_step(input int aluPct);
        bit iv, av, lv, aAcc, lAcc;
        int ir, ar, lr;
        iv = $urandom_range(99) < 40;
        ir = $urandom_range(31);
        if (iv && ir != 0 && mPend[ir] >= 3) iv = 0;
        av = !mStall && ($urandom_range(99) < aluPct);
        ar = 0;
        if (av && $urandom_range(9) != 0) begin
            ar = pick();
            if (ar < 0) begin av = 0; ar = 0; end
        end
        if (av && ar != 0) outstanding[ar]--;
        lv = $urandom_range(99) < 50;
        lr = 0;
        if (lv && $urandom_range(9) != 0) begin
            lr = pick();
            if (lr < 0) begin lv = 0; lr = 0; end
        end
        if (lv && lr != 0) outstanding[lr]--;
        step(iv, ir, av, ar, $urandom, lv, lr, $urandom, aAcc, lAcc);
        if (lv && lr != 0 && !lAcc) outstanding[lr]++;
        if (iv && ir != 0) outstanding[ir]++;
    endtask

    initial begin
        bit a, l;
        int lp;
        int longRegs[8];
        longRegs = '{1, 2, 3, 4, 11, 12, 13, 14};
        model_clear();
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs();
        Rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", LongReady, 1'b0);

        // ALU write of reg 5
        step(1, 5, 0, 0, '0, 0, 0, '0, a, l);
        step(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, '0, a, l);
        idle(3);

        // reg 0 from both paths never writes
        for (int k = 0; k < 4; k++) step(1, 0, 1, 0, 32'h1234, 1, 0, 32'h5678, a, l);
        idle(2);

        // fill the long FIFO while the ALU keeps winning, then starve into AluStall
        for (int k = 0; k < 8; k++) step(1, longRegs[k], 0, 0, '0, 0, 0, '0, a, l);
        lp = 0;
        for (int k = 0; k < 90; k++) begin
            if (!mStall)
                step(1, 7, 1, 7, $urandom, lp < 8, (lp < 8) ? longRegs[lp] : 0, 32'h11 * (lp + 1), a, l);
            else
                step(0, 0, 0, 0, '0, lp < 8, (lp < 8) ? longRegs[lp] : 0, 32'h11 * (lp + 1), a, l);
            if (l) lp++;
        end
        drain();

        // two issues to reg 9, commits interleaved with a third issue
        step(1, 9, 0, 0, '0, 0, 0, '0, a, l);
        step(1, 9, 0, 0, '0, 0, 0, '0, a, l);
        step(0, 0, 0, 0, '0, 1, 9, 32'hA0A0_0001, a, l);
        step(0, 0, 0, 0, '0, 1, 9, 32'hA0A0_0002, a, l);
        step(1, 9, 0, 0, '0, 0, 0, '0, a, l);
        step(0, 0, 0, 0, '0, 1, 9, 32'hA0A0_0003, a, l);
        idle(4);

        // reset with 3 FIFO entries and RegWrite high
        for (int r = 20; r <= 25; r++) step(1, r, 0, 0, '0, 0, 0, '0, a, l);
        step(0, 0, 1, 23, 32'hC0DE_0023, 1, 20, 32'hF1F0_0020, a, l);
        step(0, 0, 1, 24, 32'hC0DE_0024, 1, 21, 32'hF1F0_0021, a, l);
        step(0, 0, 1, 25, 32'hC0DE_0025, 1, 22, 32'hF1F0_0022, a, l);
        mid_reset();
        idle(3);

        for (int k = 0; k < 400; k++) rand_step(60);
        for (int k = 0; k < 400; k++) rand_step(95);
        drain();
        idle(2);
        check("scoreboard_empty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
